// File: rtl/iqdemap_pkg.sv
// Shared constants and mode type for the IQ demapper and its downstream writer.
package iqdemap_pkg;

  localparam int IQ_IN_W   = 11;
  localparam int IQ_WORD_W = 128;

  typedef enum logic {
    MODE_BPSK = 1'b0,
    MODE_QPSK = 1'b1
  } iq_mode_t;

endpackage

// File: rtl/iqdemap_slicer.sv
// Hard sign decision per lane: a bit is 1 only for strictly positive samples.
// Output is {bit_i, bit_q}.
module iqdemap_slicer #(
  parameter int IN_W = 11
) (
  input  logic signed [IN_W-1:0] ar,
  input  logic signed [IN_W-1:0] ai,
  output logic        [1:0]      bits
);

  logic [IN_W-1:0] samp [2];

  assign samp[0] = ai;
  assign samp[1] = ar;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    // Positive means sign bit clear and not zero.
    assign bits[gi] = ~samp[gi][IN_W-1] & (|samp[gi]);
  end

endmodule

// File: rtl/iqdemap_pack.sv
// BPSK/QPSK hard demapper packing decided bits MSB-first into WORD_W-bit words.
// Define IQDEMAP_RAW_EN to build the per-symbol raw bit tap (valid_raw/raw).
module iqdemap_pack
  import iqdemap_pkg::*;
#(
  parameter  int IN_W   = IQ_IN_W,
  parameter  int WORD_W = IQ_WORD_W,
  localparam int CNT_W  = $clog2(WORD_W + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ce,
  input  logic                     mode,
  input  logic                     flush,
  input  logic                     valid_i,
  input  logic signed [IN_W-1:0]   ar,
  input  logic signed [IN_W-1:0]   ai,
  output logic                     valid_o,
  output logic        [WORD_W-1:0] writer_data,
  output logic        [CNT_W-1:0]  fill_o,
  output logic                     valid_raw,
  output logic        [1:0]        raw
);

  logic [1:0]        bits;
  iq_mode_t          mode_act;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [WORD_W-1:0] acc_nxt;

  iq_mode_t          mode_r_q, mode_r_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              valid_o_q, valid_o_d;

  iqdemap_slicer #(.IN_W(IN_W)) u_slicer (
    .ar   (ar),
    .ai   (ai),
    .bits (bits)
  );

  // The mode input only takes effect at a word boundary; mid-word the latched mode rules.
  assign mode_act = (count_q == '0) ? iq_mode_t'(mode) : mode_r_q;

  always_comb begin
    mode_r_d  = mode_r_q;
    count_d   = count_q;
    acc_d     = acc_q;
    data_d    = data_q;
    fill_d    = fill_q;
    valid_o_d = 1'b0;
    cnt_nxt   = count_q;
    acc_nxt   = acc_q;
    if (ce) begin
      mode_r_d = mode_act;
      if (valid_i) begin
        if (mode_act == MODE_QPSK) begin
          acc_nxt = {acc_q[WORD_W-3:0], bits};
          cnt_nxt = count_q + CNT_W'(2);
        end else begin
          acc_nxt = {acc_q[WORD_W-2:0], bits[1]};
          cnt_nxt = count_q + CNT_W'(1);
        end
      end
      // A completing word wins over a same-cycle flush.
      if (cnt_nxt == CNT_W'(WORD_W)) begin
        data_d    = acc_nxt;
        fill_d    = CNT_W'(WORD_W);
        valid_o_d = 1'b1;
        count_d   = '0;
        acc_d     = '0;
      end else if (flush && (cnt_nxt != '0)) begin
        data_d    = acc_nxt << (CNT_W'(WORD_W) - cnt_nxt);
        fill_d    = cnt_nxt;
        valid_o_d = 1'b1;
        count_d   = '0;
        acc_d     = '0;
      end else begin
        count_d = cnt_nxt;
        acc_d   = acc_nxt;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_r_q  <= MODE_BPSK;
      count_q   <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      fill_q    <= '0;
      valid_o_q <= 1'b0;
    end else begin
      mode_r_q  <= mode_r_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      valid_o_q <= valid_o_d;
    end
  end

  assign valid_o     = valid_o_q;
  assign writer_data = data_q;
  assign fill_o      = fill_q;

`ifdef IQDEMAP_RAW_EN
  logic [1:0] raw_q, raw_d;
  logic       valid_raw_q, valid_raw_d;

  always_comb begin
    raw_d       = raw_q;
    valid_raw_d = 1'b0;
    if (ce && valid_i) begin
      valid_raw_d = 1'b1;
      raw_d       = (mode_act == MODE_QPSK) ? bits : {1'b0, bits[1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raw_q       <= '0;
      valid_raw_q <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      valid_raw_q <= valid_raw_d;
    end
  end

  assign raw       = raw_q;
  assign valid_raw = valid_raw_q;
`else
  assign raw       = 2'b00;
  assign valid_raw = 1'b0;
`endif

endmodule

// File: tb/tb_iqdemap_pack.sv
// Directed self-checking bench for iqdemap_pack with WORD_W = 8.
module tb_iqdemap_pack;

  localparam int IN_W   = 11;
  localparam int WORD_W = 8;
  localparam int CNT_W  = $clog2(WORD_W + 1);
`ifdef IQDEMAP_RAW_EN
  localparam logic RAW_EN = 1'b1;
`else
  localparam logic RAW_EN = 1'b0;
`endif

  logic                     CLK = 1'b0;
  logic                     RST;
  logic                     ce;
  logic                     mode;
  logic                     flush;
  logic                     valid_i;
  logic signed [IN_W-1:0]   ar;
  logic signed [IN_W-1:0]   ai;
  logic                     valid_o;
  logic        [WORD_W-1:0] writer_data;
  logic        [CNT_W-1:0]  fill_o;
  logic                     valid_raw;
  logic        [1:0]        raw;

  int errors = 0;
  int checks = 0;

  iqdemap_pack #(.IN_W(IN_W), .WORD_W(WORD_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ce          (ce),
    .mode        (mode),
    .flush       (flush),
    .valid_i     (valid_i),
    .ar          (ar),
    .ai          (ai),
    .valid_o     (valid_o),
    .writer_data (writer_data),
    .fill_o      (fill_o),
    .valid_raw   (valid_raw),
    .raw         (raw)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic step(input logic v, input int r, input int i, input logic f);
    logic [31:0] rv;
    logic [31:0] iv;
    rv = r;
    iv = i;
    valid_i = v;
    ar      = rv[IN_W-1:0];
    ai      = iv[IN_W-1:0];
    flush   = f;
    @(posedge CLK);
    #1;
    valid_i = 1'b0;
    flush   = 1'b0;
  endtask

  initial begin
    RST = 1'b1; ce = 1'b0; mode = 1'b0; flush = 1'b0; valid_i = 1'b0; ar = '0; ai = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_valid_o", 32'(valid_o), 32'h0);
    chk("reset_data", 32'(writer_data), 32'h0);
    chk("reset_fill", 32'(fill_o), 32'h0);
    chk("reset_raw", {29'd0, valid_raw, raw}, 32'h0);
    RST = 1'b0;
    ce  = 1'b1;

    // BPSK alternating +5/-5 -> 8'hAA
    mode = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, (k % 2 == 0) ? 5 : -5, 0, 1'b0);
      if (k < 7) chk("bpsk_no_early_pulse", 32'(valid_o), 32'h0);
      if (k == 0) chk("bpsk_raw_pos", {29'd0, valid_raw, raw}, RAW_EN ? 32'h5 : 32'h0);
      if (k == 1) chk("bpsk_raw_neg", {29'd0, valid_raw, raw}, RAW_EN ? 32'h4 : 32'h0);
    end
    chk("bpsk_valid", 32'(valid_o), 32'h1);
    chk("bpsk_data", 32'(writer_data), 32'hAA);
    chk("bpsk_fill", 32'(fill_o), 32'd8);
    step(1'b0, 0, 0, 1'b0);
    chk("bpsk_pulse_clears", 32'(valid_o), 32'h0);
    chk("bpsk_raw_pulse_clears", 32'(valid_raw), 32'h0);
    chk("bpsk_data_holds", 32'(writer_data), 32'hAA);

    // QPSK -> 10_01_11_00
    mode = 1'b1;
    step(1'b1, 1, -1, 1'b0);
    chk("qpsk_raw", {29'd0, valid_raw, raw}, RAW_EN ? 32'h6 : 32'h0);
    step(1'b1, -1, 1, 1'b0);
    step(1'b1, 1, 1, 1'b0);
    chk("qpsk_no_early_pulse", 32'(valid_o), 32'h0);
    step(1'b1, -1, -1, 1'b0);
    chk("qpsk_valid", 32'(valid_o), 32'h1);
    chk("qpsk_data", 32'(writer_data), 32'h9C);
    chk("qpsk_fill", 32'(fill_o), 32'd8);

    // BPSK +1,+1,0 then flush -> 8'hC0, fill 3
    mode = 1'b0;
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, 0, 0, 1'b0);
    chk("flush_zero_raw", {29'd0, valid_raw, raw}, RAW_EN ? 32'h4 : 32'h0);
    chk("flush_no_early_pulse", 32'(valid_o), 32'h0);
    step(1'b0, 0, 0, 1'b1);
    chk("flush_valid", 32'(valid_o), 32'h1);
    chk("flush_data", 32'(writer_data), 32'hC0);
    chk("flush_fill", 32'(fill_o), 32'd3);
    step(1'b0, 0, 0, 1'b1);
    chk("flush_empty_no_pulse", 32'(valid_o), 32'h0);
    chk("flush_empty_data_holds", 32'(writer_data), 32'hC0);

    // Mode change mid-word ignored: 8 BPSK bits 1011_0011, then QPSK word
    mode = 1'b0;
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, -1, 0, 1'b0);
    mode = 1'b1;
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, -1, 0, 1'b0);
    chk("modesw_no_early_pulse", 32'(valid_o), 32'h0);
    step(1'b1, -1, 0, 1'b0);
    step(1'b1, 1, 0, 1'b0);
    chk("modesw_still_filling", 32'(valid_o), 32'h0);
    step(1'b1, 1, 0, 1'b0);
    chk("modesw_valid", 32'(valid_o), 32'h1);
    chk("modesw_data", 32'(writer_data), 32'hB3);
    step(1'b1, 1, 1, 1'b0);
    step(1'b1, 1, -1, 1'b0);
    step(1'b1, -1, 1, 1'b0);
    chk("modesw_qpsk_no_early", 32'(valid_o), 32'h0);
    step(1'b1, -1, -1, 1'b0);
    chk("modesw_qpsk_valid", 32'(valid_o), 32'h1);
    chk("modesw_qpsk_data", 32'(writer_data), 32'hE4);
    chk("modesw_qpsk_fill", 32'(fill_o), 32'd8);

    // ce low for 5 cycles with valid_i=1, ar=+9 (and one flush) is ignored
    mode = 1'b0;
    step(1'b1, 1, 0, 1'b0);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 9, 0, (k == 2));
      chk("ce_low_no_raw", 32'(valid_raw), 32'h0);
      chk("ce_low_no_emit", 32'(valid_o), 32'h0);
    end
    chk("ce_low_data_holds", 32'(writer_data), 32'hE4);
    ce = 1'b1;
    for (int k = 0; k < 7; k++) step(1'b1, -1, 0, 1'b0);
    chk("ce_resume_valid", 32'(valid_o), 32'h1);
    chk("ce_resume_data", 32'(writer_data), 32'h80);
    chk("ce_resume_fill", 32'(fill_o), 32'd8);

    // Async reset mid-word (count = 5), then 8 BPSK +1 -> 8'hFF
    for (int k = 0; k < 5; k++) step(1'b1, 1, 0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_valid_o", 32'(valid_o), 32'h0);
    chk("async_rst_data", 32'(writer_data), 32'h0);
    chk("async_rst_fill", 32'(fill_o), 32'h0);
    chk("async_rst_raw", {29'd0, valid_raw, raw}, 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1, 0, 1'b0);
      if (k == 2) chk("post_rst_no_stale_count", 32'(valid_o), 32'h0);
      if (k == 6) chk("post_rst_no_early", 32'(valid_o), 32'h0);
    end
    chk("post_rst_valid", 32'(valid_o), 32'h1);
    chk("post_rst_data", 32'(writer_data), 32'hFF);
    chk("post_rst_fill", 32'(fill_o), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iqdemap_pack.md
# iqdemap_pack

Parametrised hard-decision IQ demapper and bit packer for BPSK and QPSK. It slices equalised constellation samples (ar/ai) into bits and shifts them MSB-first into a WORD_W-bit accumulator. Each full word is emitted to the downstream writer with a one-cycle valid pulse. Supported modes: BPSK, QPSK, explicit flush of partial words, and an optional per-symbol raw bit tap.

## Interface
- IN_W, 11, signed width of ar/ai
- WORD_W, 128, output word width; must be even and ≥ 4
- CNT_W, $clog2(WORD_W+1), bit-counter width (derived, not overridden)
- CLK  in  1  sole clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; when low no state advances
- mode  in  1  0 = BPSK, 1 = QPSK; sampled only at word boundary
- flush  in  1  single-cycle request to emit a partial word
- valid_i  in  1  ar/ai valid this cycle
- ar  in  IN_W signed  in-phase sample
- ai  in  IN_W signed  quadrature sample
- valid_o  out  1  one-cycle pulse: writer_data holds a word
- writer_data  out  WORD_W  packed word; earliest bit at MSB
- fill_o  out  CNT_W  number of data bits in the emitted word (WORD_W unless flushed)
- valid_raw  out  1  one-cycle pulse per accepted symbol
- raw  out  2  decided bits of last symbol; BPSK uses raw[0], raw[1]=0

## Operation
- Decision: bit_i = (ar > 0), bit_q = (ai > 0). Zero maps to 0.
- Accepted symbol = ce & valid_i.
  - BPSK: acc <= {acc[WORD_W-2:0], bit_i}; count += 1.
  - QPSK: acc <= {acc[WORD_W-3:0], bit_i, bit_q}; count += 2. I precedes Q.
- Active mode (mode_r) loads from mode only when count == 0, including just after an emit or reset. Mode changes mid-word are ignored until the next boundary.
- Full: when the post-update count == WORD_W, register writer_data <= acc, fill_o <= WORD_W, and pulse valid_o; count <= 0 in the same cycle.
- Flush (ce & flush) with count > 0, after including any symbol accepted the same cycle:
  - emit acc << (WORD_W − count), so data is MSB-aligned with zero padding;
  - fill_o <= count; count <= 0.
- Flush with count == 0: no emit.
- Flush in the same cycle as a word completing: the full word is emitted; nothing extra.
- State machine, held in count/mode_r:
  - EMPTY (count = 0): mode may load.
  - FILL (0 < count < WORD_W): → EMPTY on full or flush.
  - No stall or backpressure exists. The downstream must accept one word per pulse.
- Raw tap: on each accepted symbol, raw <= {bit_i, bit_q} (QPSK) or {1'b0, bit_i} (BPSK), and valid_raw pulses.

## Timing
- Reset values: valid_o = 0, writer_data = 0, fill_o = 0, valid_raw = 0, raw = 0, count = 0, acc = 0, mode_r = 0 (BPSK).
- Latency:
  - valid_o rises the cycle after the accepting/flush edge.
  - valid_raw/raw are valid one cycle after acceptance.
- valid_o and valid_raw are single-cycle pulses. They are cleared on the next CLK edge regardless of ce.
- ce low: acc, count, mode_r, writer_data and raw hold; valid_i and flush are ignored.
- Reset mid-word: the partial word is discarded with no emit, and mode returns to BPSK.
- Throughput: one symbol per cycle. A word is emitted every WORD_W (BPSK) or WORD_W/2 (QPSK) accepted symbols.

## Configuration
- IQDEMAP_RAW_EN defined: raw tap implemented as above.
- Not defined: valid_raw and raw are tied to 0, and their registers are removed. Packing behaviour is unchanged.

## Structure
- Shared package iqdemap_pkg:
  - MODE_BPSK = 1'b0, MODE_QPSK = 1'b1;
  - iq_mode_t typedef;
  - default IN_W and WORD_W constants, shared with the writer.
- One sub-module, iqdemap_slicer: combinational sign decision producing {bit_i, bit_q} from ar/ai. Reused by future 16-QAM work.
- Top contains the counter, accumulator, flush alignment shifter and output registers.

## Test plan
- BPSK, WORD_W = 8, ar alternating +5/−5 for 8 symbols → one valid_o pulse, writer_data = 8'hAA, fill_o = 8.
- QPSK, WORD_W = 8, symbols (ar, ai) = (+1,−1), (−1,+1), (+1,+1), (−1,−1) → writer_data = 8'b10_01_11_00, fill_o = 8.
- BPSK, 3 symbols ar = +1, +1, 0 then flush → writer_data = 8'b1100_0000, fill_o = 3. A further flush produces no pulse.
- mode switched BPSK→QPSK after 2 BPSK symbols → word completes after 8 BPSK bits. QPSK applies from the next word (4 symbols/word).
- ce low for 5 cycles with valid_i = 1 and ar = +9 → no count change, no valid_raw. Accumulation resumes with ce high.
- RST asserted asynchronously mid-word (count = 5), then 8 BPSK symbols of +1 → single word 8'hFF. All outputs read 0 during reset.
